// File: rtl/rca_mw_seq.sv
// rca_mw_seq -- multi-word add/subtract sequencer.
//
// Purpose:
//   Adds or subtracts two width*nwords-bit operands with one width-bit
//   ripple-carry adder (RCA). The adder works on one slice per clock,
//   least significant slice first. A register carries each slice's
//   carry-out into the next slice's carry-in. Subtraction is computed
//   as a + ~b + 1, so the same adder does both operations.
//
// Parameters:
//   width  - slice width of the RCA instance (>= 2)
//   nwords - number of slices per operand (>= 1), W = width*nwords
//
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset
//   start in  1  request pulse, only honoured while idle
//   sub   in  1  0 = a+b, 1 = a-b, captured with start
//   a     in  W  operand A, captured with start
//   b     in  W  operand B, captured with start
//   busy  out 1  high while slices are being processed
//   done  out 1  one-cycle pulse when the result is complete
//   sum   out W  result register
//   cout  out 1  final carry (for subtract: 1 = no borrow)
//   ovf   out 1  signed two's-complement overflow of the full operation

// Plain ripple-carry adder: a chain of full adders, one per bit.
module RCA #(
  parameter int width = 4
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  input  logic             i_cin,
  output logic [width-1:0] o_sum,
  output logic             o_cout
);

  logic [width:0] w_carry;

  assign w_carry[0] = i_cin;

  // Each bit is a full adder. Its carry feeds the next bit up the chain.
  genvar gi;
  generate
    for (gi = 0; gi < width; gi++) begin : g_bit
      assign o_sum[gi]      = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_carry[width];

endmodule

module rca_mw_seq #(
  parameter int width  = 4,
  parameter int nwords = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sub,
  input  logic [width*nwords-1:0] a,
  input  logic [width*nwords-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [width*nwords-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W  = width * nwords;
  localparam int IW = (nwords > 1) ? $clog2(nwords) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(nwords - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_bEff;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IW-1:0]    r_idx;

  logic [width-1:0] w_aSlice;
  logic [width-1:0] w_bSlice;
  logic [width-1:0] w_rcaSum;
  logic             w_rcaCout;
  logic             w_lastSlice;

  // The slice at the current index goes to the single shared adder.
  // The carry-in comes from the previous slice, or from sub for the
  // first slice. That is where the +1 of a - b is added.
  assign w_aSlice    = r_a[r_idx*width +: width];
  assign w_bSlice    = r_bEff[r_idx*width +: width];
  assign w_lastSlice = (r_idx == LAST_IDX);

  RCA #(
    .width (width)
  ) u_rca (
    .i_a    (w_aSlice),
    .i_b    (w_bSlice),
    .i_cin  (r_carry),
    .o_sum  (w_rcaSum),
    .o_cout (w_rcaCout)
  );

  // State register. Reset wins over everything and abandons a run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode.
  // start is looked at only while idle, so a request that arrives
  // during RUN or DONE is dropped, not queued.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastSlice) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers.
  // On an accepted start, the operands are copied so that later changes on
  // a and b have no effect. b is stored already inverted for subtract.
  // During RUN, one result slice is written per edge. On the last slice the
  // final carry and the signed overflow are also latched. Overflow uses the
  // sign bits of a and of b as actually added (b_eff): it is set when they
  // agree but the sign of the new result differs from them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_bEff  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_bEff  <= sub ? ~b : b;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_carry <= sub;
          end
        end
        RUN: begin
          r_sum[r_idx*width +: width] <= w_rcaSum;
          r_carry                     <= w_rcaCout;
          if (w_lastSlice) begin
            r_idx  <= '0;
            r_cout <= w_rcaCout;
            r_ovf  <= (r_a[W-1] == r_bEff[W-1]) && (w_rcaSum[width-1] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_rca_mw_seq.sv
// tb_rca_mw_seq -- self-checking bench for rca_mw_seq (width=4, nwords=4).
//
// Directed vectors come from a table. Random operations are checked
// against an arithmetic model. Hand-written sequences cover a start
// request during a run, a change of operands during a run, and a reset
// in the middle of a run.
module tb_rca_mw_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[5];

  rca_mw_seq #(
    .width  (4),
    .nwords (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and keep the running counts.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model. It uses plain integer arithmetic on the unsigned and
  // signed views of the operands and does not look at slices.
  task automatic refModel(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rs, output logic rc, output logic ro);
    int ux;
    int uy;
    int sx;
    int sy;
    int full;
    int sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      full = ux - uy;
      rc   = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy;
      rc   = (full > 65535);
      sres = sx + sy;
    end
    rs = full[W-1:0];
    ro = (sres > 32767) || (sres < -32768);
  endtask

  // Start one operation and follow it to done. Checks: busy and done
  // timing, the result, and that the result is held afterwards.
  // With disturb set, a second start is issued and the operands are
  // changed while the operation is running.
  task automatic applyStimulus(input string name, input logic s, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] expSum,
                               input logic expCout, input logic expOvf, input logic disturb);
    int busyCnt;
    int doneAt;
    int doneCnt;
    busyCnt = 0;
    doneAt  = 0;
    doneCnt = 0;
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, " sumClear"}, 32'(sum), 32'h0);
    for (int n = 1; n <= 20 && doneAt == 0; n++) begin
      if (disturb && n == 2) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h5A5A;
        sub   = ~s;
      end
      if (disturb && n == 3) begin
        start = 1'b0;
        a     = 16'h0F0F;
      end
      if (done) begin
        doneAt = n;
        doneCnt++;
      end else if (busy) begin
        busyCnt++;
      end
      if (doneAt == 0) @(negedge clk);
    end
    checkOutput({name, " doneLatency"}, 32'(doneAt), 32'd5);
    checkOutput({name, " busyCycles"}, 32'(busyCnt), 32'd4);
    checkOutput({name, " sum"}, 32'(sum), 32'(expSum));
    checkOutput({name, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({name, " ovf"}, 32'(ovf), 32'(expOvf));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) doneCnt++;
      checkOutput({name, " idleBusy"}, 32'(busy), 32'h0);
    end
    checkOutput({name, " doneCount"}, 32'(doneCnt), 32'd1);
    checkOutput({name, " heldSum"}, 32'(sum), 32'(expSum));
    checkOutput({name, " heldFlags"}, {30'h0, cout, ovf}, {30'h0, expCout, expOvf});
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rsub;
    int           doneSeen;

    checks = 0;
    errors = 0;

    vecs[0] = '{"add",      1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{"ripple",   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"addOvf",   1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"subOvf",   1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{"subBorrow",1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetDone", 32'(done), 32'h0);
    checkOutput("resetSum", 32'(sum), 32'h0);
    checkOutput("resetFlags", {30'h0, cout, ovf}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b,
                    vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b0);
    end

    // A start request during RUN, plus operand changes, must not affect the result.
    applyStimulus("ignoredStart", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b1);

    // Reset during the second RUN cycle.
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'h1234;
    b     = 16'h0FCD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetDone", 32'(done), 32'h0);
    checkOutput("midResetSum", 32'(sum), 32'h0);
    checkOutput("midResetCout", 32'(cout), 32'h0);
    doneSeen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("midResetNoActivity", 32'(doneSeen), 32'h0);
    applyStimulus("afterReset", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random operations, checked against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rx   = 16'($urandom);
      ry   = 16'($urandom);
      rsub = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ry = rx ^ 16'h8000;
      refModel(rsub, rx, ry, rs, rc, ro);
      applyStimulus($sformatf("rand%0d", i), rsub, rx, ry, rs, rc, ro, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_mw_seq.md
Name: rca_mw_seq

Overview:
- Multi-word add/subtract sequencer built around one instance of the team's `RCA` ripple-carry adder, `width` bits wide.
- Captures two wide operands, then feeds them through the adder one `width`-bit slice per cycle, LSB slice first, chaining each carry-out into the next carry-in through a register.
- Produces a `width*nwords`-bit result plus carry and overflow flags.
- Used wherever long-operand arithmetic is needed at low area cost, trading latency for a single narrow adder.

Parameters:
- `width`, 4, slice width passed to the `RCA` instance; legal range ≥ 2.
- `nwords`, 4, number of slices per operand; legal range ≥ 1; total operand width `W = width*nwords`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `sub`  in  1  0 = a+b, 1 = a−b; captured with `start`.
- `a`  in  W  operand A; captured with `start`.
- `b`  in  W  operand B; captured with `start`.
- `busy`  out  1  high while slices are being processed.
- `done`  out  1  one-cycle pulse when the result is complete.
- `sum`  out  W  result register.
- `cout`  out  1  final carry; for subtract, 1 means no borrow (a ≥ b unsigned).
- `ovf`  out  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. All state is updated only on the rising edge of `clk`.
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0, `ovf` = 0. Internal slice index, carry register and operand registers are also cleared.
- Reset mid-operation: `rst` high in any state returns the block to IDLE with reset values on the next edge. The partial result is discarded and no `done` pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 at an edge captures `a`, `b` and `sub`.
  - Stores `b_eff = sub ? ~b : b`.
  - Clears `sum`, `cout` and `ovf`.
  - Sets index = 0 and carry register = `sub`.
  - Moves to RUN.
- RUN (`busy` = 1):
  - `RCA` inputs are A slice[idx], B_eff slice[idx] and the carry register as `cin`.
  - At each edge: `sum` slice[idx] ← `RCA` sum; carry register ← `RCA` `cout`; idx ← idx+1.
  - When idx = `nwords`−1 at the edge, also load `cout` ← `RCA` `cout` and `ovf` ← (a[W−1] == b_eff[W−1]) && (new sum[W−1] != a[W−1]), then go to DONE.
- DONE: `done` = 1 and `busy` = 0 for exactly one cycle, then unconditional return to IDLE.
- Latency: with `start` sampled at edge 0, slice k is written at edge k+1 and `done` is high in the cycle following edge `nwords`. A new `start` is accepted no earlier than edge `nwords`+2.
- `start` in RUN or DONE is ignored: not queued, no effect on the operation in progress.
- Operand stability: `a`, `b` and `sub` may change freely after capture; the result depends only on the captured values.
- Result hold: `sum`, `cout` and `ovf` hold their final values from the DONE cycle until the next accepted `start` or `rst`.
- Arithmetic: all operations are modulo 2^W. Subtract is a + ~b + 1 using the `RCA` carry-in; no separate subtractor.
- `nwords` = 1: RUN lasts one cycle, and `cout`/`ovf` load on that same edge.
- Exactly one `RCA` instance with parameter `width`. No other adder logic is allowed, apart from the idx increment.

Test Plan (`width` = 4, `nwords` = 4, W = 16):
- Basic add: `start`, `sub`=0, a=0x1234, b=0x0FCD → `busy` high 4 cycles, `done` pulse 5 cycles after `start`, `sum`=0x2201, `cout`=0, `ovf`=0.
- Full carry ripple: a=0xFFFF, b=0x0001, add → `sum`=0x0000, `cout`=1, `ovf`=0; carry must propagate across all 4 slices.
- Signed overflow on add: a=0x7FFF, b=0x0001, add → `sum`=0x8000, `cout`=0, `ovf`=1.
- Subtract, both flag cases:
  - a=0x8000, b=0x0001, `sub`=1 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
  - a=0x0003, b=0x0005, `sub`=1 → `sum`=0xFFFE, `cout`=0 (borrow), `ovf`=0.
- Ignored start and operand change: during RUN of 0x1234+0x0FCD, pulse `start` with a=0xFFFF and change `a`/`b` → result still 0x2201; exactly one `done`; values held in IDLE afterwards.
- Reset mid-run: assert `rst` on the 2nd RUN cycle → next cycle IDLE, `busy`=0, `done` never pulses, `sum`=0. A following `start` with 0x0001+0x0001 → `sum`=0x0002 with normal latency.
